// File: rtl/seq_subtractor_64bit_if.sv
// Start/ready/done bus for the sequential subtractor.
// SEQ_SUB_OVF_FLAG_EN adds the signed-overflow flag ovf.
interface seq_subtractor_64bit_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SEQ_SUB_OVF_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output start, in1, in2, bin,
    input  ready, busy, done, diff, bout
`ifdef SEQ_SUB_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, in1, in2, bin,
    output ready, busy, done, diff, bout
`ifdef SEQ_SUB_OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/seq_subtractor_64bit.sv
// Multi-cycle subtractor diff = in1 - in2 - bin, one SLICE-bit chunk per clock, LSB first.
// Optional macro SEQ_SUB_OVF_FLAG_EN registers a signed-overflow flag alongside diff.
module seq_subtractor_64bit #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_subtractor_64bit_if.slave bus
);
  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] w_next;
  logic             c;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   sum;

  // Two's-complement slice subtract: carry out of the MSB is the inverted borrow.
  function automatic logic [SLICE:0] slice_sub(input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y,
                                                input logic             cin);
    return {1'b0, x} + {1'b0, ~y} + {{SLICE{1'b0}}, cin};
  endfunction

  always_comb begin
    a_sl   = a[idx*SLICE +: SLICE];
    b_sl   = b[idx*SLICE +: SLICE];
    sum    = slice_sub(a_sl, b_sl, c);
    w_next = w;
    w_next[idx*SLICE +: SLICE] = sum[SLICE-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a         <= '0;
      b         <= '0;
      w         <= '0;
      c         <= 1'b0;
      bus.diff  <= '0;
      bus.bout  <= 1'b0;
      bus.done  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.ready <= 1'b1;
`ifdef SEQ_SUB_OVF_FLAG_EN
      bus.ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a         <= bus.in1;
            b         <= bus.in2;
            c         <= ~bus.bin;
            idx       <= '0;
            w         <= '0;
            state     <= RUN;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
          end
        end
        RUN: begin
          w <= w_next;
          c <= sum[SLICE];
          // Outputs only move on the last slice; partial results stay in w.
          if (idx == LAST) begin
            bus.diff <= w_next;
            bus.bout <= ~sum[SLICE];
`ifdef SEQ_SUB_OVF_FLAG_EN
            bus.ovf  <= (a[WIDTH-1] != b[WIDTH-1]) && (w_next[WIDTH-1] != a[WIDTH-1]);
`endif
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          bus.done  <= 1'b0;
          bus.busy  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_subtractor_64bit.sv
// Scoreboard bench for seq_subtractor_64bit: expected results queued at drive time,
// popped and compared on each done pulse.
module tb_seq_subtractor_64bit;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_subtractor_64bit_if #(.WIDTH(64)) bus ();

  seq_subtractor_64bit #(.WIDTH(64), .SLICE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_done = -1;
  int   done_gap = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic bi);
    logic [64:0] r;
    exp_t        e;
    r      = {1'b0, x} - {1'b0, y} - {64'b0, bi};
    e.diff = r[63:0];
    e.bout = r[64];
    e.ovf  = (x[63] != y[63]) && (r[63] != x[63]);
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'b0, bus.done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("diff", bus.diff, e.diff);
        check("bout", {63'b0, bus.bout}, {63'b0, e.bout});
`ifdef SEQ_SUB_OVF_FLAG_EN
        check("ovf", {63'b0, bus.ovf}, {63'b0, e.ovf});
`endif
      end
      if (last_done >= 0) done_gap = cyc - last_done;
      last_done = cyc;
    end
  end

  task automatic do_op(input logic [63:0] x, input logic [63:0] y, input logic bi, input bit poke);
    int   k;
    exp_t e;
    k = 0;
    while (!bus.ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_op", {63'b0, bus.ready}, 64'd1);
    @(negedge clk);
    bus.in1   = x;
    bus.in2   = y;
    bus.bin   = bi;
    bus.start = 1'b1;
    e = model(x, y, bi);
    sb.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (poke && k == 2) begin
        bus.start = 1'b1;
        bus.in1   = ~x;
        bus.in2   = y ^ 64'h1234_5678;
        bus.bin   = ~bi;
      end
      if (poke && k == 3) bus.start = 1'b0;
    end while (!bus.done && k < 20);
    check("done_latency", 64'(k), 64'd4);
    @(posedge clk);
    #1;
    check("done_single_cycle", {63'b0, bus.done}, 64'd0);
    @(posedge clk);
    #1;
    check("diff_hold", bus.diff, e.diff);
    check("ready_back", {63'b0, bus.ready}, 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'b0, bus.ready}, 64'd1);
    check("rst_busy",  {63'b0, bus.busy},  64'd0);
    check("rst_done",  {63'b0, bus.done},  64'd0);
    check("rst_diff",  bus.diff,           64'd0);
    check("rst_bout",  {63'b0, bus.bout},  64'd0);
`ifdef SEQ_SUB_OVF_FLAG_EN
    check("rst_ovf",   {63'b0, bus.ovf},   64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    do_op(64'd4036, 64'd2917, 1'b0, 1'b0);
    do_op(64'd0, 64'd1, 1'b0, 1'b0);
    do_op(64'd4294967295, 64'd4294967295, 1'b1, 1'b0);
    do_op(64'd10000000000000000000, 64'd7500000000000000000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);

    // Abandon an operation after two slices.
    @(negedge clk);
    bus.in1   = 64'd100;
    bus.in2   = 64'd50;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("busy_in_run", {63'b0, bus.busy}, 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {63'b0, bus.ready}, 64'd1);
    check("midrst_busy",  {63'b0, bus.busy},  64'd0);
    check("midrst_diff",  bus.diff,           64'd0);
    check("midrst_bout",  {63'b0, bus.bout},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    do_op(64'd5, 64'd3, 1'b0, 1'b0);

    // start held high: two accepts, done pulses N+2 cycles apart.
    last_done = -1;
    done_gap  = 0;
    @(negedge clk);
    bus.in1   = 64'd900;
    bus.in2   = 64'd1000;
    bus.bin   = 1'b1;
    bus.start = 1'b1;
    sb.push_back(model(64'd900, 64'd1000, 1'b1));
    sb.push_back(model(64'd900, 64'd1000, 1'b1));
    repeat (7) @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (12) @(posedge clk);
    check("b2b_gap", 64'(done_gap), 64'd6);

`ifdef SEQ_SUB_OVF_FLAG_EN
    do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0);
    do_op(64'd5, 64'd3, 1'b0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
